ex_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage RV32I pipeline. It owns the execute stage and generates these controls:
- ForwardA_E/ForwardB_E selects for the EX operand muxes (00 = RD1/RD2, 01 = ResultW, 10 = ALU_ResultM).
- Load-use stalls.
- Branch flushes.
- Multi-cycle hold of EX while a long-latency op (iterative multiply) completes.

It also keeps saturating performance counters for stall cycles and branch flushes.

---
 rtl/ex_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard and sequencing controller for the 5-stage RV32I pipeline.
// Produces EX operand forward selects, load-use stalls, branch flushes, a
// multi-cycle hold of EX for long-latency ops, and saturating perf counters.
module ex_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic             LongOpE,
    input  logic             cnt_clr,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             BubbleM,
    output logic             LongBusy,
    output logic             LongDone,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // BUSY lasts MUL_LAT-2 cycles; the entry cycle and DONE make up the rest.
    localparam logic [3:0] LAT_LOAD = 4'(MUL_LAT - 2);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [3:0] lat_r;
    logic [3:0] lat_nxt_s;
    logic       lu_s;
    logic       long_hold_s;

    // Forward select for one operand: M stage beats W stage, x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       we_m,
        input logic [4:0] rd_m,
        input logic       we_w,
        input logic [4:0] rd_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            fwd_sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            fwd_sel = 2'b01;
        end else begin
            fwd_sel = 2'b00;
        end
    endfunction

    // Hazard detection and prioritised pipeline controls; all held low in reset.
    always_comb begin
        ForwardA_E  = 2'b00;
        ForwardB_E  = 2'b00;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        BubbleM     = 1'b0;
        LongBusy    = 1'b0;
        LongDone    = 1'b0;
        lu_s        = ResultSrcE && (RD_E != 5'd0) &&
                      ((RD_E == Rs1_D) || (RD_E == Rs2_D));
        long_hold_s = (state_r == BUSY) || ((state_r == IDLE) && LongOpE);
        if (!rst) begin
            ForwardA_E = 2'b00;
            ForwardB_E = 2'b00;
        end else begin
            ForwardA_E = fwd_sel(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
            ForwardB_E = fwd_sel(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);
            LongBusy   = (state_r == BUSY);
            LongDone   = (state_r == DONE);
            if (long_hold_s) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                BubbleM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lu_s) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else begin
                StallF = 1'b0;
            end
        end
    end

    // Long-op sequencing: entry -> BUSY countdown -> single DONE cycle.
    always_comb begin
        state_nxt_s = state_r;
        lat_nxt_s   = lat_r;
        case (state_r)
            IDLE: begin
                if (LongOpE) begin
                    lat_nxt_s   = LAT_LOAD;
                    state_nxt_s = (LAT_LOAD == 4'd0) ? DONE : BUSY;
                end else begin
                    lat_nxt_s   = 4'd0;
                end
            end
            BUSY: begin
                if (lat_r <= 4'd1) begin
                    lat_nxt_s   = 4'd0;
                    state_nxt_s = DONE;
                end else begin
                    lat_nxt_s   = lat_r - 4'd1;
                end
            end
            DONE: begin
                lat_nxt_s   = 4'd0;
                state_nxt_s = IDLE;
            end
            default: begin
                lat_nxt_s   = 4'd0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and latency counter registers; reset aborts any long op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            lat_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            lat_r   <= lat_nxt_s;
        end
    end

    // Saturating stall/flush counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= CNT_ZERO;
            flush_cnt <= CNT_ZERO;
        end else if (cnt_clr) begin
            stall_cnt <= CNT_ZERO;
            flush_cnt <= CNT_ZERO;
        end else begin
            if (StallF && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (FlushD && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: per-cycle vector records are pushed
// to a scoreboard when driven and popped/compared at the following negedge.
module tb_ex_hazard_ctrl;

    localparam int CW  = 4;
    localparam int SAT = 15;

    // control vector bit order: {StallF,StallD,StallE,FlushD,FlushE,BubbleM,LongBusy,LongDone}
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_LU    = 8'b1100_1000;
    localparam logic [7:0] C_BR    = 8'b0001_1000;
    localparam logic [7:0] C_ENTRY = 8'b1110_0100;
    localparam logic [7:0] C_BUSY  = 8'b1110_0110;
    localparam logic [7:0] C_DONE  = 8'b0000_0001;

    typedef struct {
        string      name;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, rse, pcs, lop, clr;
        logic [1:0] fa, fb;
        logic [7:0] ctl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
    logic RegWriteM, RegWriteW, ResultSrcE, PCSrcE, LongOpE, cnt_clr;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic StallF, StallD, StallE, FlushD, FlushE, BubbleM, LongBusy, LongDone;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int m_stall = 0;
    int m_flush = 0;
    vec_t sb[$];
    vec_t tbl[15];

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.MUL_LAT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .LongOpE(LongOpE), .cnt_clr(cnt_clr),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
        .LongBusy(LongBusy), .LongDone(LongDone),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic vec_t mk(
        input string n,
        input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
        input logic rwm, rww, rse, pcs, lop, clr,
        input logic [1:0] fa, fb,
        input logic [7:0] ctl
    );
        vec_t v;
        v.name = n;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw;
        v.rwm = rwm; v.rww = rww; v.rse = rse; v.pcs = pcs; v.lop = lop; v.clr = clr;
        v.fa = fa; v.fb = fb; v.ctl = ctl;
        return v;
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [7:0] ctl_now();
        return {StallF, StallD, StallE, FlushD, FlushE, BubbleM, LongBusy, LongDone};
    endfunction

    task automatic drive(input vec_t v);
        Rs1_D = v.rs1d; Rs2_D = v.rs2d; Rs1_E = v.rs1e; Rs2_E = v.rs2e;
        RD_E = v.rde; RD_M = v.rdm; RD_W = v.rdw;
        RegWriteM = v.rwm; RegWriteW = v.rww; ResultSrcE = v.rse;
        PCSrcE = v.pcs; LongOpE = v.lop; cnt_clr = v.clr;
    endtask

    // one cycle: drive after posedge, compare at negedge, then advance counter model
    task automatic step(input vec_t v);
        vec_t e;
        @(posedge clk); #1;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, "/fwdA"}, 16'(ForwardA_E), 16'(e.fa));
        chk({e.name, "/fwdB"}, 16'(ForwardB_E), 16'(e.fb));
        chk({e.name, "/ctl"}, 16'(ctl_now()), 16'(e.ctl));
        chk({e.name, "/stall_cnt"}, 16'(stall_cnt), 16'(m_stall));
        chk({e.name, "/flush_cnt"}, 16'(flush_cnt), 16'(m_flush));
        if (e.clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (e.ctl[7] && m_stall < SAT) m_stall++;
            if (e.ctl[4] && m_flush < SAT) m_flush++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle, lu, lop;
        idle = mk("idle", 0,0,0,0,0,0,0, 0,0,0,0,0,0, 2'b00,2'b00, C_NONE);
        lu   = mk("lu",   0,7,0,0,7,0,0, 0,0,1,0,0,0, 2'b00,2'b00, C_LU);

        //                   rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rse pcs lop clr fa fb ctl
        tbl[0]  = mk("fwdA_M",   0, 0, 5, 0, 0, 5, 5, 1,1,0,0,0,0, 2'b10,2'b00, C_NONE);
        tbl[1]  = mk("fwdA_W",   0, 0, 5, 0, 0, 5, 5, 0,1,0,0,0,0, 2'b01,2'b00, C_NONE);
        tbl[2]  = mk("fwd_x0",   0, 0, 0, 0, 0, 0, 0, 1,1,0,0,0,0, 2'b00,2'b00, C_NONE);
        tbl[3]  = mk("fwdB_M",   0, 0, 3, 9, 0, 9, 3, 1,1,0,0,0,0, 2'b01,2'b10, C_NONE);
        tbl[4]  = mk("fwdB_W",   0, 0, 4, 9, 0, 4, 9, 1,1,0,0,0,0, 2'b10,2'b01, C_NONE);
        tbl[5]  = mk("fwd_noWE", 0, 0, 6, 6, 0, 6, 6, 0,0,0,0,0,0, 2'b00,2'b00, C_NONE);
        tbl[6]  = mk("lu_rs2",   0, 7, 0, 0, 7, 0, 0, 0,0,1,0,0,0, 2'b00,2'b00, C_LU);
        tbl[7]  = mk("lu_rd0",   0, 0, 0, 0, 0, 0, 0, 0,0,1,0,0,0, 2'b00,2'b00, C_NONE);
        tbl[8]  = mk("lu_rs1",  12, 0, 0, 0,12, 0, 0, 0,0,1,0,0,0, 2'b00,2'b00, C_LU);
        tbl[9]  = mk("lu_noLd", 12, 0, 0, 0,12, 0, 0, 0,0,0,0,0,0, 2'b00,2'b00, C_NONE);
        tbl[10] = mk("br_vs_lu", 0, 7, 0, 0, 7, 0, 0, 0,0,1,1,0,0, 2'b00,2'b00, C_BR);
        tbl[11] = mk("br_only",  0, 0, 0, 0, 0, 0, 0, 0,0,0,1,0,0, 2'b00,2'b00, C_BR);
        tbl[12] = mk("clr",      0, 0, 0, 0, 0, 0, 0, 0,0,0,0,0,1, 2'b00,2'b00, C_NONE);
        tbl[13] = mk("lu_clr",   0, 7, 0, 0, 7, 0, 0, 0,0,1,0,0,1, 2'b00,2'b00, C_LU);
        tbl[14] = mk("idle_clr", 0, 0, 0, 0, 0, 0, 0, 0,0,0,0,0,1, 2'b00,2'b00, C_NONE);

        // reset: outputs low even with forwarding and long-op inputs active
        rst = 1'b0;
        drive(mk("rst", 0,7,5,0,7,5,5, 1,1,1,0,1,0, 2'b00,2'b00, C_NONE));
        #3;
        chk("reset/fwdA", 16'(ForwardA_E), 16'd0);
        chk("reset/ctl", 16'(ctl_now()), 16'd0);
        chk("reset/stall_cnt", 16'(stall_cnt), 16'd0);
        chk("reset/flush_cnt", 16'(flush_cnt), 16'd0);
        #9;
        drive(idle);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) step(tbl[i]);

        // long op, MUL_LAT=4: entry + 2 BUSY stall, then DONE; branch in BUSY ignored
        lop = mk("long_entry", 0,0,0,0,0,0,0, 0,0,0,0,1,0, 2'b00,2'b00, C_ENTRY);
        step(lop);
        lop.name = "long_busy_br"; lop.pcs = 1'b1; lop.ctl = C_BUSY; step(lop);
        lop.name = "long_busy2";   lop.pcs = 1'b0; step(lop);
        lop.name = "long_done";    lop.ctl = C_DONE; step(lop);
        step(idle);
        chk("long/stall_total", 16'(m_stall), 16'd3);
        step(idle);

        // reset mid long op: immediate zero outputs, no LongDone afterwards
        lop = mk("rlong_entry", 0,0,5,0,0,5,0, 1,0,0,0,1,0, 2'b10,2'b00, C_ENTRY);
        step(lop);
        lop.name = "rlong_busy"; lop.ctl = C_BUSY; step(lop);
        #2; rst = 1'b0; #1;
        chk("midrst/fwdA", 16'(ForwardA_E), 16'd0);
        chk("midrst/ctl", 16'(ctl_now()), 16'd0);
        chk("midrst/stall_cnt", 16'(stall_cnt), 16'd0);
        drive(idle);
        m_stall = 0;
        m_flush = 0;
        #1; rst = 1'b1;
        for (int i = 0; i < 3; i++) step(idle);
        lop = mk("relong_entry", 0,0,0,0,0,0,0, 0,0,0,0,1,0, 2'b00,2'b00, C_ENTRY);
        step(lop);
        lop.name = "relong_busy"; lop.ctl = C_BUSY; step(lop); step(lop);
        lop.name = "relong_done"; lop.ctl = C_DONE; step(lop);
        step(idle);

        // saturation at 15 then clear beating a simultaneous stall
        for (int i = 0; i < 20; i++) step(lu);
        chk("sat/model", 16'(m_stall), 16'(SAT));
        lu.name = "lu_sat_clr"; lu.clr = 1'b1; step(lu);
        step(idle);
        step(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
